// File: rtl/div_f_writeback.sv
// div_f_writeback: collects divide-lane results, buffers unmasked ones and writes them to the vector register bank
// Ports: start/vlr_i/dest_reg_i launch an operation; result_i = {valid, mask, data} from the divide lane;
// wr_* is the arbitrated register-bank write port (head pops on wr_grant_i); busy_o/done_o/overflow_o report status.
module div_f_writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int MVL = 32,
  parameter int ID = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int IW = $clog2(MVL) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IW-1:0]         vlr_i,
  input  logic [4:0]            dest_reg_i,
  input  logic [DATA_WIDTH+1:0] result_i,
  input  logic                  wr_grant_i,
  output logic                  wr_en_o,
  output logic [4:0]            wr_reg_o,
  output logic [IW-1:0]         wr_addr_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overflow_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
  state_t state;
  logic [IW-1:0] cnt, vlr, cnt_inc;
  logic [4:0] dest;
  logic [IW+DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [AW:0] occ, occ_next;
  logic overflow, accept, push, pop, empty, full, unused_id;
  assign unused_id = ^ID;
  always_comb begin
    empty = occ == '0;
    full = occ == FULL;
    accept = state == COLLECT && result_i[DATA_WIDTH+1];
    pop = !empty && wr_grant_i;
    // a simultaneous pop frees the slot, so a push into a full FIFO still succeeds
    push = accept && result_i[DATA_WIDTH] && (!full || pop);
    occ_next = occ + (AW + 1)'(push) - (AW + 1)'(pop);
    cnt_inc = cnt + 1'b1;
  end
  assign wr_en_o = !empty;
  assign wr_reg_o = dest;
  assign wr_addr_o = empty ? '0 : mem[rd][IW+DATA_WIDTH-1:DATA_WIDTH];
  assign wr_data_o = empty ? '0 : mem[rd][DATA_WIDTH-1:0];
  assign busy_o = state == COLLECT || state == DRAIN;
  assign done_o = state == DONE;
  assign overflow_o = overflow;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      vlr <= '0;
      dest <= '0;
      rd <= '0;
      wr <= '0;
      occ <= '0;
      overflow <= 1'b0;
    end else if (start) begin
      state <= vlr_i == '0 ? DONE : COLLECT;
      cnt <= '0;
      vlr <= vlr_i;
      dest <= dest_reg_i;
      rd <= '0;
      wr <= '0;
      occ <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) cnt <= cnt_inc;
      if (push) begin
        mem[wr] <= {cnt, result_i[DATA_WIDTH-1:0]};
        wr <= wr + 1'b1;
      end
      if (pop) rd <= rd + 1'b1;
      occ <= occ_next;
      if (accept && result_i[DATA_WIDTH] && full && !pop) overflow <= 1'b1;
      // DRAIN looks at next-cycle occupancy so done follows the final pop by one cycle
      state <= state == COLLECT ? (accept && cnt_inc == vlr ? DRAIN : COLLECT) :
               state == DRAIN ? (occ_next == '0 ? DONE : DRAIN) : IDLE;
    end
  end
endmodule

// File: tb/tb_div_f_writeback.sv
// tb_div_f_writeback: directed and random stimulus checked against a queue-based reference model
module tb_div_f_writeback;
  localparam int DEPTH = 4;
  localparam int P_IDLE = 0, P_COL = 1, P_DRAIN = 2, P_DONE = 3;
  typedef struct packed {logic [5:0] a; logic [31:0] d;} ent_t;
  logic clk = 0, reset = 0, start = 0, valid = 0, mask = 0, wr_grant_i = 0;
  logic [5:0] vlr_i = 0;
  logic [4:0] dest_reg_i = 0;
  logic [31:0] data = 0;
  logic [33:0] result_i;
  logic wr_en_o, busy_o, done_o, overflow_o;
  logic [4:0] wr_reg_o;
  logic [5:0] wr_addr_o;
  logic [31:0] wr_data_o;
  int checks = 0, errors = 0, nwr = 0, ndone = 0, budget;
  ent_t q[$];
  int m_phase = P_IDLE, m_idx = 0, m_vlr = 0;
  logic [4:0] m_reg = 0;
  logic m_ovf = 0;
  assign result_i = {valid, mask, data};
  always #5 clk = ~clk;
  div_f_writeback dut (
    .clk(clk), .reset(reset), .start(start), .vlr_i(vlr_i), .dest_reg_i(dest_reg_i),
    .result_i(result_i), .wr_grant_i(wr_grant_i), .wr_en_o(wr_en_o), .wr_reg_o(wr_reg_o),
    .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .busy_o(busy_o), .done_o(done_o),
    .overflow_o(overflow_o)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_update();
    int sz;
    bit popped, acc;
    if (reset) begin
      q.delete(); m_phase = P_IDLE; m_idx = 0; m_vlr = 0; m_reg = 0; m_ovf = 0;
    end else if (start) begin
      q.delete(); m_idx = 0; m_vlr = int'(vlr_i); m_reg = dest_reg_i; m_ovf = 0;
      m_phase = vlr_i == 0 ? P_DONE : P_COL;
    end else begin
      sz = q.size();
      popped = sz > 0 && wr_grant_i;
      acc = m_phase == P_COL && valid;
      if (popped) void'(q.pop_front());
      if (acc && mask) begin
        if (sz < DEPTH || popped) q.push_back({6'(m_idx), data});
        else m_ovf = 1;
      end
      if (acc) m_idx++;
      if (m_phase == P_COL) m_phase = (acc && m_idx == m_vlr) ? P_DRAIN : P_COL;
      else if (m_phase == P_DRAIN) m_phase = q.size() == 0 ? P_DONE : P_DRAIN;
      else m_phase = P_IDLE;
    end
  endtask
  task automatic tick();
    if (wr_en_o === 1'b1 && wr_grant_i && !reset && !start) nwr++;
    if (done_o === 1'b1) ndone++;
    model_update();
    @(posedge clk);
    @(negedge clk);
    chk("wr_en", wr_en_o, q.size() > 0);
    chk("wr_addr", wr_addr_o, q.size() > 0 ? q[0].a : 6'd0);
    chk("wr_data", wr_data_o, q.size() > 0 ? q[0].d : 32'd0);
    chk("wr_reg", wr_reg_o, m_reg);
    chk("busy", busy_o, m_phase == P_COL || m_phase == P_DRAIN);
    chk("done", done_o, m_phase == P_DONE);
    chk("overflow", overflow_o, m_ovf);
  endtask
  task automatic begin_op(input int v, input int d);
    start = 1; vlr_i = 6'(v); dest_reg_i = 5'(d); valid = 0;
    tick();
    start = 0;
  endtask
  task automatic send(input bit m, input logic [31:0] dat, input bit g);
    valid = 1; mask = m; data = dat; wr_grant_i = g;
    tick();
    valid = 0;
  endtask
  task automatic idle(input int n, input bit g);
    valid = 0; wr_grant_i = g;
    for (int i = 0; i < n; i++) tick();
  endtask
  initial begin
    @(negedge clk);
    reset = 1;
    tick();
    tick();
    reset = 0;
    idle(1, 1);
    nwr = 0; ndone = 0;
    wr_grant_i = 1;
    begin_op(4, 3);
    send(1, 32'h3F800000, 1);
    send(1, 32'h40000000, 1);
    send(1, 32'h40400000, 1);
    send(1, 32'h40800000, 1);
    idle(4, 1);
    chk("t1_writes", nwr, 4);
    chk("t1_done", ndone, 1);
    nwr = 0; ndone = 0;
    begin_op(6, 7);
    for (int i = 0; i < 6; i++) send(i % 2 == 0, 32'h1000 + i, 1);
    idle(4, 1);
    chk("t2_writes", nwr, 3);
    chk("t2_done", ndone, 1);
    nwr = 0; ndone = 0;
    wr_grant_i = 0;
    begin_op(8, 9);
    for (int i = 0; i < 8; i++) send(1, 32'hA000 + i, 0);
    idle(2, 0);
    chk("t3_overflow", overflow_o, 1);
    idle(8, 1);
    chk("t3_writes", nwr, 4);
    chk("t3_done", ndone, 1);
    nwr = 0; ndone = 0;
    wr_grant_i = 0;
    begin_op(4, 10);
    for (int i = 0; i < 4; i++) send(1, 32'hB000 + i, i >= 3);
    idle(6, 1);
    chk("t3b_writes", nwr, 4);
    chk("t3b_overflow", overflow_o, 0);
    chk("t3b_done", ndone, 1);
    nwr = 0; ndone = 0;
    begin_op(0, 2);
    idle(3, 1);
    chk("t4_writes", nwr, 0);
    chk("t4_done", ndone, 1);
    ndone = 0;
    begin_op(5, 4);
    send(1, 32'hC000, 1);
    send(1, 32'hC001, 1);
    begin_op(3, 5);
    for (int i = 0; i < 3; i++) send(1, 32'hD000 + i, 1);
    idle(4, 1);
    chk("t5_done", ndone, 1);
    nwr = 0; ndone = 0;
    wr_grant_i = 0;
    begin_op(4, 6);
    for (int i = 0; i < 4; i++) send(1, 32'hE000 + i, 0);
    idle(1, 0);
    reset = 1;
    tick();
    reset = 0;
    idle(5, 1);
    chk("t5b_writes", nwr, 0);
    chk("t5b_done", ndone, 0);
    nwr = 0; ndone = 0;
    for (int i = 0; i < 3; i++) send(1, 32'hF000 + i, 1);
    begin_op(2, 8);
    send(1, 32'h12345678, 1);
    send(1, 32'h9ABCDEF0, 1);
    idle(3, 1);
    chk("t6_writes", nwr, 2);
    chk("t6_done", ndone, 1);
    for (int op = 0; op < 25; op++) begin
      begin_op($urandom_range(0, 12), $urandom_range(0, 31));
      budget = 0;
      while (m_phase != P_IDLE && budget < 300) begin
        valid = $urandom_range(0, 9) < 6;
        mask = $urandom_range(0, 9) < 7;
        data = $urandom;
        wr_grant_i = $urandom_range(0, 3) != 0;
        start = $urandom_range(0, 79) == 0;
        if (start) begin
          vlr_i = 6'($urandom_range(0, 12));
          dest_reg_i = 5'($urandom_range(0, 31));
        end
        tick();
        start = 0;
        budget++;
      end
      valid = 0;
      chk("rand_completes", budget < 300, 1);
      idle(1, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
